// File: rtl/hamming_decoder.sv
// -----------------------------------------------------------------------------
// hamming_decoder
//   Serial Hamming(7,4) single-error-correcting decoder. Codewords arrive one
//   bit per clk_fast cycle, position 1 first and position 7 last, back to back
//   with free-running framing. Each codeword is decoded when its last bit
//   arrives. The corrected data nibble appears on po1 and is re-serialised
//   LSB-first on serial_out.
//
//   Optional feature macro: HAMMING_ERR_STATUS_EN
//     When defined, adds err_flag and syndrome status outputs.
//
// Ports
//   clk_fast      in   1  sole clock, rising edge
//   rst           in   1  synchronous, active-high reset
//   serial_in     in   1  codeword bit stream
//   serial_out    out  1  decoded data bits, LSB first (0 when idle)
//   serial_valid  out  1  high while serial_out carries a data bit
//   po1           out  4  last decoded nibble {d4,d3,d2,d1}
//   po_valid      out  1  one-cycle pulse after po1 updates
//   err_flag      out  1  (HAMMING_ERR_STATUS_EN) syndrome was nonzero
//   syndrome      out  3  (HAMMING_ERR_STATUS_EN) {s4,s2,s1} of last frame
// -----------------------------------------------------------------------------
module hamming_decoder (
   input  logic       clk_fast,
   input  logic       rst,
   input  logic       serial_in,
   output logic       serial_out,
   output logic       serial_valid,
   output logic [3:0] po1,
   output logic       po_valid
`ifdef HAMMING_ERR_STATUS_EN
   ,
   output logic       err_flag,
   output logic [2:0] syndrome
`endif
);

   // Even-parity syndrome {s4,s2,s1} of a codeword indexed by position.
   function automatic logic [2:0] calc_syndrome(input logic [7:1] cw);
      logic s1, s2, s4;
      s1 = cw[1] ^ cw[3] ^ cw[5] ^ cw[7];
      s2 = cw[2] ^ cw[3] ^ cw[6] ^ cw[7];
      s4 = cw[4] ^ cw[5] ^ cw[6] ^ cw[7];
      return {s4, s2, s1};
   endfunction

   // Flip the position named by the syndrome; syndrome 0 leaves it untouched.
   function automatic logic [7:1] correct(input logic [7:1] cw,
                                          input logic [2:0] syn);
      logic [7:1] fixed;
      for (int k = 1; k <= 7; k++)
         fixed[k] = cw[k] ^ (syn == 3'(k));
      return fixed;
   endfunction

   logic [2:0] bit_cnt;
   logic [5:0] rx_bits_p0;
   logic       last_bit_p0;
   logic [7:1] cw_p0;
   logic [2:0] syn_p0;
   logic [7:1] cor_p0;
   logic [3:0] nib_p0;
   logic [3:0] ser_sr_p1;
   logic [2:0] ser_cnt_p1;

   // ---- stage p0: framing and capture of positions 1..6 ----
   // rx_bits_p0 shifts right with new bits entering at the MSB, so after six
   // shifts bit 0 holds position 1 and bit 5 holds position 6. It also shifts
   // on the position-7 edge; the next frame overwrites all six bits anyway.
   always_ff @(posedge clk_fast) begin
      if (rst) begin
         bit_cnt    <= 3'd0;
         rx_bits_p0 <= 6'd0;
      end else begin
         bit_cnt    <= (bit_cnt == 3'd6) ? 3'd0 : bit_cnt + 3'd1;
         rx_bits_p0 <= {serial_in, rx_bits_p0[5:1]};
      end
   end

   assign last_bit_p0 = (bit_cnt == 3'd6);

   // Decode on the six stored bits plus the live position-7 bit.
   assign cw_p0  = {serial_in, rx_bits_p0};
   assign syn_p0 = calc_syndrome(cw_p0);
   assign cor_p0 = correct(cw_p0, syn_p0);
   assign nib_p0 = {cor_p0[7], cor_p0[6], cor_p0[5], cor_p0[3]};

   // ---- stage p1: parallel result and serialiser ----
   always_ff @(posedge clk_fast) begin
      if (rst) begin
         po1        <= 4'd0;
         po_valid   <= 1'b0;
         ser_sr_p1  <= 4'd0;
         ser_cnt_p1 <= 3'd0;
      end else if (last_bit_p0) begin
         po1        <= nib_p0;
         po_valid   <= 1'b1;
         ser_sr_p1  <= nib_p0;
         ser_cnt_p1 <= 3'd4;
      end else begin
         po_valid <= 1'b0;
         if (ser_cnt_p1 != 3'd0) begin
            ser_sr_p1  <= {1'b0, ser_sr_p1[3:1]};
            ser_cnt_p1 <= ser_cnt_p1 - 3'd1;
         end
      end
   end

   assign serial_valid = (ser_cnt_p1 != 3'd0);
   assign serial_out   = serial_valid & ser_sr_p1[0];

`ifdef HAMMING_ERR_STATUS_EN
   always_ff @(posedge clk_fast) begin
      if (rst) begin
         err_flag <= 1'b0;
         syndrome <= 3'd0;
      end else if (last_bit_p0) begin
         err_flag <= (syn_p0 != 3'd0);
         syndrome <= syn_p0;
      end
   end
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// -----------------------------------------------------------------------------
// tb_hamming_decoder
//   Directed and streamed checks of the serial Hamming(7,4) decoder. Inputs
//   change on the falling edge; outputs are checked on the falling edge just
//   before each new input bit is driven.
// -----------------------------------------------------------------------------
module tb_hamming_decoder;

   logic       clk_fast = 1'b0;
   logic       rst = 1'b1;
   logic       serial_in = 1'b0;
   logic       serial_out;
   logic       serial_valid;
   logic [3:0] po1;
   logic       po_valid;
`ifdef HAMMING_ERR_STATUS_EN
   logic       err_flag;
   logic [2:0] syndrome;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Expected-state model of the outputs.
   logic [3:0] exp_po1 = 4'd0;
   logic       exp_err = 1'b0;
   logic [2:0] exp_syn = 3'd0;
   bit         have_out = 1'b0;
   int         ph = 100;

   hamming_decoder dut (
      .clk_fast     (clk_fast),
      .rst          (rst),
      .serial_in    (serial_in),
      .serial_out   (serial_out),
      .serial_valid (serial_valid),
      .po1          (po1),
      .po_valid     (po_valid)
`ifdef HAMMING_ERR_STATUS_EN
      ,
      .err_flag     (err_flag),
      .syndrome     (syndrome)
`endif
   );

   always #5 clk_fast = ~clk_fast;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic logic [7:1] encode(input logic [3:0] d);
      logic [7:1] cw;
      cw[3] = d[0];
      cw[5] = d[1];
      cw[6] = d[2];
      cw[7] = d[3];
      cw[1] = d[0] ^ d[1] ^ d[3];
      cw[2] = d[0] ^ d[2] ^ d[3];
      cw[4] = d[1] ^ d[2] ^ d[3];
      return cw;
   endfunction

   // Check all outputs against the model (called on a falling edge).
   task automatic check_outputs(input string tag);
      logic exp_pv, exp_sv, exp_so;
      exp_pv = have_out && (ph == 0);
      exp_sv = have_out && (ph < 4);
      exp_so = exp_sv ? exp_po1[ph[1:0]] : 1'b0;
      n_checks++;
      assert (po1 === exp_po1) else begin
         n_errors++;
         $error("FAIL %s po1 got=%b exp=%b", tag, po1, exp_po1);
      end
      n_checks++;
      assert (po_valid === exp_pv) else begin
         n_errors++;
         $error("FAIL %s po_valid got=%b exp=%b ph=%0d", tag, po_valid, exp_pv, ph);
      end
      n_checks++;
      assert (serial_valid === exp_sv) else begin
         n_errors++;
         $error("FAIL %s serial_valid got=%b exp=%b ph=%0d", tag, serial_valid, exp_sv, ph);
      end
      n_checks++;
      assert (serial_out === exp_so) else begin
         n_errors++;
         $error("FAIL %s serial_out got=%b exp=%b ph=%0d", tag, serial_out, exp_so, ph);
      end
`ifdef HAMMING_ERR_STATUS_EN
      n_checks++;
      assert (err_flag === exp_err) else begin
         n_errors++;
         $error("FAIL %s err_flag got=%b exp=%b", tag, err_flag, exp_err);
      end
      n_checks++;
      assert (syndrome === exp_syn) else begin
         n_errors++;
         $error("FAIL %s syndrome got=%0d exp=%0d", tag, syndrome, exp_syn);
      end
`endif
   endtask

   // Check, drive one bit, advance to the next falling edge.
   task automatic step(input logic b, input string tag);
      check_outputs(tag);
      serial_in = b;
      @(negedge clk_fast);
      ph++;
   endtask

   // Send a codeword (positions 1..7) and update the model with its result.
   task automatic send_frame(input logic [7:1] cw, input logic [3:0] nib,
                             input logic [2:0] syn, input string tag);
      for (int k = 1; k <= 7; k++)
         step(cw[k], tag);
      exp_po1  = nib;
      exp_err  = (syn != 3'd0);
      exp_syn  = syn;
      have_out = 1'b1;
      ph       = 0;
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      serial_in = 1'b0;
      repeat (cycles) @(negedge clk_fast);
      exp_po1  = 4'd0;
      exp_err  = 1'b0;
      exp_syn  = 3'd0;
      have_out = 1'b0;
      ph       = 100;
      check_outputs("reset");
      rst = 1'b0;
   endtask

   initial begin
      logic [7:1] cw;
      logic [3:0] nib;
      logic [2:0] syn;
      int         pos;

      @(negedge clk_fast);
      do_reset(3);

      // Hand-computed vectors (position 1 is the LSB of each literal here).
      send_frame(7'b1010111, 4'b1011, 3'd2, "err_pos2");   // 1,1,1,0,1,0,1
      send_frame(7'b1010101, 4'b1011, 3'd0, "clean_b");    // 1,0,1,0,1,0,1
      send_frame(7'b1001100, 4'b1001, 3'd0, "clean_9");    // 0,0,1,1,0,0,1

      // Data 0110 encodes to 1,1,0,0,1,1,0; flip each position in turn.
      for (int p = 1; p <= 7; p++) begin
         cw = 7'b0110011;
         cw[p] = ~cw[p];
         send_frame(cw, 4'b0110, 3'(p), "single_err");
      end
      send_frame(7'b0110011, 4'b0110, 3'd0, "clean_6");

      // Reset three bits into a frame; the partial frame must vanish.
      step(1'b1, "partial");
      step(1'b0, "partial");
      step(1'b1, "partial");
      do_reset(2);
      send_frame(7'b1001100, 4'b1001, 3'd0, "post_reset");

      // Streamed random nibbles with zero or one error each.
      for (int f = 0; f < 50; f++) begin
         nib = 4'($urandom_range(0, 15));
         cw  = encode(nib);
         syn = 3'd0;
         if ($urandom_range(0, 1) == 1) begin
            pos = int'($urandom_range(1, 7));
            cw[pos] = ~cw[pos];
            syn = 3'(pos);
         end
         send_frame(cw, nib, syn, "stream");
      end

      // Idle tail lets the last frame's serial output be checked.
      for (int i = 0; i < 6; i++)
         step(1'b0, "tail");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
